multi_port_fifo: RTL and testbench

Parametrised multi-port synchronous FIFO accepting up to PUSH_PORTS entries and releasing up to POP_PORTS entries per cycle. It sits between fetch and decode as the instruction queue, and is reusable wherever a superscalar stage hands a variable number of items per cycle to the next. It generalises the single-port ring-buffer FIFO with batch push/pop, occupancy outputs, and defined head data when entries are absent.

---
 rtl/multi_port_fifo.sv | 87 ++++++++
 tb/tb_multi_port_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multi_port_fifo.sv
// Multi-port ring-buffer FIFO: up to PUSH_PORTS entries in and POP_PORTS entries out per cycle.
// Pointers carry an extra wrap bit, so occupancy is just wp - rp.
module multi_port_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned PUSH_PORTS = 2,
  parameter int unsigned POP_PORTS  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [$clog2(PUSH_PORTS+1)-1:0]     push_num,
  input  logic [PUSH_PORTS*LINE_WIDTH-1:0]    push_data,
  output logic                                push_ready,
  input  logic [$clog2(POP_PORTS+1)-1:0]      pop_num,
  output logic [POP_PORTS*LINE_WIDTH-1:0]     head_data,
  output logic [POP_PORTS-1:0]                head_valid,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic [$clog2(DEPTH+1)-1:0]          free_slots,
  output logic                                full,
  output logic                                empty
);

  localparam int unsigned IDX   = $clog2(DEPTH);
  localparam int unsigned PTR   = IDX + 1;
  localparam int unsigned CNT   = $clog2(DEPTH + 1);
  localparam int unsigned POPW  = $clog2(POP_PORTS + 1);

  logic [PTR-1:0]        rp;
  logic [PTR-1:0]        wp;
  logic [PTR-1:0]        occ;
  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic                  push_ok;
  logic [POPW-1:0]       pop_eff;

  assign occ        = wp - rp;
  assign count      = CNT'(occ);
  assign free_slots = CNT'(DEPTH) - count;
  assign full       = (count == CNT'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = (free_slots >= CNT'(PUSH_PORTS));

  // Push is all-or-nothing against the free space seen before this cycle's pop.
  assign push_ok = (CNT'(push_num) <= free_slots);

  always_comb begin
    pop_eff = pop_num;
    if (CNT'(pop_num) > count)
      pop_eff = POPW'(count);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
    end else if (flush) begin
      rp <= '0;
      wp <= '0;
    end else begin
      if (push_ok)
        wp <= wp + PTR'(push_num);
      rp <= rp + PTR'(pop_eff);
    end
  end

  // Storage has no reset; stale lines are never visible because head output is gated by occupancy.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) begin
      for (int unsigned k = 0; k < PUSH_PORTS; k++) begin
        if (k < 32'(push_num))
          mem[wp[IDX-1:0] + IDX'(k)] <= push_data[k*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  always_comb begin
    head_valid = '0;
    head_data  = '0;
    for (int unsigned i = 0; i < POP_PORTS; i++) begin
      if (32'(count) > i) begin
        head_valid[i]                          = 1'b1;
        head_data[i*LINE_WIDTH +: LINE_WIDTH]  = mem[rp[IDX-1:0] + IDX'(i)];
      end
    end
  end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed bench for multi_port_fifo (DEPTH=8, 2 push / 2 pop ports, 32-bit lines).
module tb_multi_port_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  push_num;
  logic [63:0] push_data;
  logic        push_ready;
  logic [1:0]  pop_num;
  logic [63:0] head_data;
  logic [1:0]  head_valid;
  logic [3:0]  count;
  logic [3:0]  free_slots;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  multi_port_fifo #(
    .DEPTH(8),
    .LINE_WIDTH(32),
    .PUSH_PORTS(2),
    .POP_PORTS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push_num(push_num),
    .push_data(push_data),
    .push_ready(push_ready),
    .pop_num(pop_num),
    .head_data(head_data),
    .head_valid(head_valid),
    .count(count),
    .free_slots(free_slots),
    .full(full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic        f;
    logic [1:0]  pn;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  pp;
    logic [3:0]  cnt;
    logic [1:0]  hv;
    logic [31:0] h0;
    logic [31:0] h1;
    logic        fu;
    logic        em;
    logic        rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic [1:0] pn,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] pp,
                     input logic [3:0] cnt, input logic [1:0] hv,
                     input logic [31:0] h0, input logic [31:0] h1,
                     input logic fu, input logic em, input logic rd);
    vec_t v;
    v = '{r: r, f: f, pn: pn, d0: d0, d1: d1, pp: pp, cnt: cnt, hv: hv,
          h0: h0, h1: h1, fu: fu, em: em, rd: rd};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] cnt, input logic [1:0] hv,
                             input logic [31:0] h0, input logic [31:0] h1,
                             input logic fu, input logic em, input logic rd);
    check({tag, " count"},      32'(count),            32'(cnt));
    check({tag, " free_slots"}, 32'(free_slots),       32'(4'd8 - cnt));
    check({tag, " head_valid"}, 32'(head_valid),       32'(hv));
    check({tag, " head0"},      head_data[31:0],       h0);
    check({tag, " head1"},      head_data[63:32],      h1);
    check({tag, " full"},       32'(full),             32'(fu));
    check({tag, " empty"},      32'(empty),            32'(em));
    check({tag, " push_ready"}, 32'(push_ready),       32'(rd));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_num = '0; push_data = '0; pop_num = '0;

    //  r  f  pn  d0        d1        pp  cnt hv     h0        h1        fu em rd
    add(1, 0, 0, 32'h0,    32'h0,    0,  0, 2'b00, 32'h0,    32'h0,    0, 1, 1); // reset
    add(0, 0, 2, 32'hD00A, 32'hD00B, 0,  2, 2'b11, 32'hD00A, 32'hD00B, 0, 0, 1); // A,B
    add(0, 0, 2, 32'hD00C, 32'hD00D, 0,  4, 2'b11, 32'hD00A, 32'hD00B, 0, 0, 1);
    add(0, 0, 2, 32'hD00E, 32'hD00F, 0,  6, 2'b11, 32'hD00A, 32'hD00B, 0, 0, 1);
    add(0, 0, 1, 32'hD010, 32'h0,    0,  7, 2'b11, 32'hD00A, 32'hD00B, 0, 0, 0); // G at idx 6
    add(0, 0, 2, 32'hD011, 32'hD012, 0,  7, 2'b11, 32'hD00A, 32'hD00B, 0, 0, 0); // rejected
    add(0, 0, 1, 32'hD013, 32'h0,    0,  8, 2'b11, 32'hD00A, 32'hD00B, 1, 0, 0); // full
    add(0, 0, 0, 32'h0,    32'h0,    2,  6, 2'b11, 32'hD00C, 32'hD00D, 0, 0, 1);
    add(0, 0, 0, 32'h0,    32'h0,    2,  4, 2'b11, 32'hD00E, 32'hD00F, 0, 0, 1);
    add(0, 0, 0, 32'h0,    32'h0,    2,  2, 2'b11, 32'hD010, 32'hD013, 0, 0, 1); // G,J intact
    add(0, 0, 0, 32'h0,    32'h0,    2,  0, 2'b00, 32'h0,    32'h0,    0, 1, 1);
    add(0, 0, 0, 32'h0,    32'h0,    2,  0, 2'b00, 32'h0,    32'h0,    0, 1, 1); // underflow
    add(0, 0, 2, 32'hD014, 32'hD015, 0,  2, 2'b11, 32'hD014, 32'hD015, 0, 0, 1);
    add(0, 0, 2, 32'hD016, 32'hD017, 2,  2, 2'b11, 32'hD016, 32'hD017, 0, 0, 1);
    add(0, 0, 2, 32'hD018, 32'hD019, 2,  2, 2'b11, 32'hD018, 32'hD019, 0, 0, 1);
    add(0, 0, 0, 32'h0,    32'h0,    2,  0, 2'b00, 32'h0,    32'h0,    0, 1, 1); // rp idx 6
    add(0, 0, 1, 32'hD01A, 32'h0,    0,  1, 2'b01, 32'hD01A, 32'h0,    0, 0, 1);
    add(0, 0, 2, 32'hD01B, 32'hD01C, 0,  3, 2'b11, 32'hD01A, 32'hD01B, 0, 0, 1); // straddle write
    add(0, 0, 0, 32'h0,    32'h0,    1,  2, 2'b11, 32'hD01B, 32'hD01C, 0, 0, 1); // straddle read
    add(0, 0, 0, 32'h0,    32'h0,    2,  0, 2'b00, 32'h0,    32'h0,    0, 1, 1);
    add(0, 0, 1, 32'hD020, 32'h0,    0,  1, 2'b01, 32'hD020, 32'h0,    0, 0, 1); // X
    add(0, 0, 2, 32'hD021, 32'hD022, 2,  2, 2'b11, 32'hD021, 32'hD022, 0, 0, 1); // pop clamps to 1
    add(0, 0, 2, 32'hD030, 32'hD031, 0,  4, 2'b11, 32'hD021, 32'hD022, 0, 0, 1);
    add(0, 0, 1, 32'hD032, 32'h0,    0,  5, 2'b11, 32'hD021, 32'hD022, 0, 0, 1);
    add(0, 1, 2, 32'hD033, 32'hD034, 0,  0, 2'b00, 32'h0,    32'h0,    0, 1, 1); // flush wins
    add(0, 0, 2, 32'hD033, 32'hD034, 0,  2, 2'b11, 32'hD033, 32'hD034, 0, 0, 1);
    add(0, 0, 2, 32'hD035, 32'hD036, 0,  4, 2'b11, 32'hD033, 32'hD034, 0, 0, 1);
    add(0, 0, 2, 32'hD037, 32'hD038, 0,  6, 2'b11, 32'hD033, 32'hD034, 0, 0, 1);
    add(0, 0, 1, 32'hD039, 32'h0,    0,  7, 2'b11, 32'hD033, 32'hD034, 0, 0, 0);
    add(0, 0, 2, 32'hD03A, 32'hD03B, 2,  5, 2'b11, 32'hD035, 32'hD036, 0, 0, 1); // push rejected pre-pop

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].r;
      flush     = vecs[i].f;
      push_num  = vecs[i].pn;
      push_data = {vecs[i].d1, vecs[i].d0};
      pop_num   = vecs[i].pp;
      @(posedge clk);
      #1;
      check_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].hv, vecs[i].h0, vecs[i].h1,
                  vecs[i].fu, vecs[i].em, vecs[i].rd);
    end

    // Async reset mid-stream: outputs clear with no clock edge in between.
    push_num = 2'd2; push_data = {32'hD041, 32'hD040}; pop_num = 2'd1; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 4'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_state("rst_held", 4'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    rst = 1'b0; pop_num = 2'd0;
    @(posedge clk);
    #1;
    check_state("post_rst", 4'd2, 2'b11, 32'hD040, 32'hD041, 1'b0, 1'b0, 1'b1);

    // Pops of one at a time, then hold: head slot 1 drops out as occupancy falls.
    push_num = 2'd0; pop_num = 2'd1;
    @(posedge clk);
    #1;
    check_state("pop_one", 4'd1, 2'b01, 32'hD041, 32'h0, 1'b0, 1'b0, 1'b1);
    pop_num = 2'd0;
    @(posedge clk);
    #1;
    check_state("hold", 4'd1, 2'b01, 32'hD041, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
